// File: rtl/forwarding_scoreboard.sv
// EX-stage forward-select generation and load-use stall control for FWD_STAGES tracked post-EX stages.
// Build option FWD_WB_BYPASS_EN: track one extra stage for register files without write-through.
module forwarding_scoreboard #(
   parameter  int REG_ADDR_W = 5,
   parameter  int NUM_SRC    = 2,
   parameter  int FWD_STAGES = 2,
   parameter  int LOAD_LAT   = 1,
   localparam int SEL_W      = $clog2(FWD_STAGES + 2)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          id_valid,
   input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
   input  logic [NUM_SRC-1:0]            id_rs_used,
   input  logic [REG_ADDR_W-1:0]         id_rd,
   input  logic                          id_reg_write,
   input  logic                          id_mem_read,
   input  logic                          flush,
   output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
   output logic                          stall
);
`ifdef FWD_WB_BYPASS_EN
   localparam int NUM_ENT = FWD_STAGES + 1;
`else
   localparam int NUM_ENT = FWD_STAGES;
`endif
   localparam int CNT_W  = 3;
   // Loads still this close to EX have not produced data yet and must keep stalling dependents.
   localparam int LD_WIN = (LOAD_LAT - 1 < NUM_ENT) ? LOAD_LAT - 1 : NUM_ENT;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
   } entry_t;

   entry_t                        sb [NUM_ENT+1];
   logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs;
   logic [NUM_SRC-1:0]            ex_rs_used;
   logic [CNT_W-1:0]              stall_cnt;
   logic                          detect;
   logic                          capture;

   always_comb begin
      detect = 1'b0;
      for (int k = 0; k <= LD_WIN; k++) begin
         if (sb[k].valid && sb[k].mem_read && sb[k].rd != '0) begin
            for (int i = 0; i < NUM_SRC; i++) begin
               if (id_rs_used[i] && id_rs[i*REG_ADDR_W +: REG_ADDR_W] == sb[k].rd)
                  detect = 1'b1;
            end
         end
      end
      detect = detect && id_valid;
   end

   assign stall   = !flush && (detect || stall_cnt != '0);
   assign capture = id_valid && !stall && !flush;

   // Scan oldest to youngest so the youngest matching producer overrides.
   always_comb begin
      fwd_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = NUM_ENT; k >= 1; k--) begin
            if (ex_rs_used[i] && ex_rs[i*REG_ADDR_W +: REG_ADDR_W] != '0 &&
                sb[k].valid && sb[k].reg_write &&
                sb[k].rd == ex_rs[i*REG_ADDR_W +: REG_ADDR_W])
               fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= NUM_ENT; k++) sb[k] <= '0;
         ex_rs      <= '0;
         ex_rs_used <= '0;
         stall_cnt  <= '0;
      end else begin
         for (int k = 1; k <= NUM_ENT; k++) sb[k] <= sb[k-1];
         if (capture) begin
            sb[0]      <= '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
            ex_rs      <= id_rs;
            ex_rs_used <= id_rs_used;
         end else begin
            sb[0]      <= '0;
            ex_rs_used <= '0;
         end
         if (flush)
            stall_cnt <= '0;
         else if (stall_cnt != '0)
            stall_cnt <= stall_cnt - CNT_W'(1);
         else if (detect)
            stall_cnt <= CNT_W'(LOAD_LAT - 1);
      end
   end
endmodule
